// File: rtl/stack_pkg.sv
// Shared types and constants for the stack block and its command front-end.
package stack_pkg;

  localparam int STACK_DW = 4;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_REL = 1'b1
  } stack_cmd_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: synchronizer, stability counter, stable level and one-cycle rise pulse.
module btn_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  // Any cycle where the synced level matches the stable level restarts the count,
  // so only an uninterrupted run of DB_CYCLES differing cycles flips the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      rise <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= ~level;
        rise  <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stack_cmd_ctrl.sv
// Push/pop command front-end for the stack: debounced buttons to gated one-cycle strobes.
// Optional sticky ERR output is enabled by defining STACK_CMD_ERR_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | both buttons released, waiting for a single rise event
// WAIT_REL | press handled (or dropped); waiting for both to release
import stack_pkg::*;

module stack_cmd_ctrl #(
  parameter int DW          = STACK_DW,
  parameter int DB_CYCLES   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          BTN_PUSH,
  input  logic          BTN_POP,
  input  logic [DW-1:0] DATA_RAW,
  input  logic          FULL,
  input  logic          EMPTY,
  output logic          PUSH,
  output logic          POP,
`ifdef STACK_CMD_ERR_EN
  output logic          ERR,
`endif
  output logic [DW-1:0] DATA_OUT
);

  stack_cmd_state_t state, state_nxt;

  logic          push_level, push_rise;
  logic          pop_level, pop_rise;
  logic          push_nxt, pop_nxt, load_data;
  logic [DW-1:0] data_sync [SYNC_STAGES];

  btn_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES)
  ) u_db_push (
    .clk  (CLK),
    .rst_n(RST_N),
    .raw  (BTN_PUSH),
    .level(push_level),
    .rise (push_rise)
  );

  btn_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES)
  ) u_db_pop (
    .clk  (CLK),
    .rst_n(RST_N),
    .raw  (BTN_POP),
    .level(pop_level),
    .rise (pop_rise)
  );

  // Data bits are only consumed while the button has been stable for many cycles,
  // so per-bit synchronizers without bus coherency are sufficient.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
    end else begin
      data_sync[0] <= DATA_RAW;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
    end
  end

  always_comb begin
    state_nxt = state;
    push_nxt  = 1'b0;
    pop_nxt   = 1'b0;
    load_data = 1'b0;
    case (state)
      IDLE: begin
        if (push_rise && pop_rise) begin
          state_nxt = WAIT_REL;
        end else if (push_rise) begin
          state_nxt = WAIT_REL;
          push_nxt  = !FULL;
          load_data = !FULL;
        end else if (pop_rise) begin
          state_nxt = WAIT_REL;
          pop_nxt   = !EMPTY;
        end
      end
      WAIT_REL: begin
        if (!push_level && !pop_level) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      PUSH     <= 1'b0;
      POP      <= 1'b0;
      DATA_OUT <= '0;
    end else begin
      state <= state_nxt;
      PUSH  <= push_nxt;
      POP   <= pop_nxt;
      if (load_data) DATA_OUT <= data_sync[SYNC_STAGES-1];
    end
  end

`ifdef STACK_CMD_ERR_EN
  logic err_set;

  assign err_set = (state == IDLE) &&
                   ((push_rise && pop_rise) ||
                    (push_rise && FULL) ||
                    (pop_rise && EMPTY));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ERR <= 1'b0;
    else if (err_set) ERR <= 1'b1;
  end
`endif

endmodule
